// File: rtl/osr_pull_if.sv
// TX FIFO read handshake between the FIFO (master) and the OSR (slave).
// A word moves on any cycle where valid && ready.
interface osr_pull_if #(
    parameter int DW = 32
);
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/osr_pull.sv
// Output shift register for one PIO state machine. It handles OUT, PULL,
// MOV-to-OSR and autopull, and it requests sequencer stalls when data is missing.
// Optional OSR_PREFETCH_EN: a one-entry buffer in front of the FIFO. When it is
// enabled, every load reads the buffer, so autopull never waits on FIFO latency.
module osr_pull #(
    parameter int DW  = 32,
    parameter int SHW = $clog2(DW),
    parameter int CW  = $clog2(DW) + 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           penable,
    input  logic           restart,
    input  logic           stalled,
    input  logic           dir,
    input  logic [SHW-1:0] shift,
    input  logic [SHW-1:0] thresh,
    input  logic           autopull_en,
    input  logic           do_shift,
    input  logic           do_pull,
    input  logic           pull_block,
    input  logic [DW-1:0]  x_val,
    input  logic           mov_set,
    input  logic [DW-1:0]  mov_din,
    osr_pull_if.slave      fifo,
    output logic [DW-1:0]  dout,
    output logic [CW-1:0]  shift_count,
    output logic           empty,
    output logic           stall_req
);
    localparam logic [CW-1:0] FULL = CW'(DW);
    localparam logic [DW-1:0] ONES = '1;

    logic [DW-1:0] shift_reg;
    logic [CW-1:0] count;

    logic [CW-1:0] sv;
    logic [CW-1:0] thresh_eff;
    logic [CW:0]   count_sum;
    logic [CW-1:0] count_post;
    logic [DW-1:0] shifted;
    logic [DW-1:0] shout;
    logic          avail;
    logic [DW-1:0] load_data;
    logic          active;
    logic          pull_noop;
    logic          go;
    logic          mov_op;
    logic          pull_op;
    logic          out_op;
    logic          out_reload;
    logic          out_shift;
    logic          out_chain;
    logic          load;
    logic          xload;

`ifdef OSR_PREFETCH_EN
    logic          pf_valid;
    logic [DW-1:0] pf_data;

    assign avail      = pf_valid;
    assign load_data  = pf_data;
    // Refill whenever the buffer is empty or is being drained this cycle.
    assign fifo.ready = reset_n && fifo.valid && (!pf_valid || load);
`else
    assign avail      = fifo.valid;
    assign load_data  = fifo.data;
    assign fifo.ready = load && fifo.valid;
`endif

    assign shift_count = count;

    // Shift amount, thresholds, saturating count and the decode of this cycle's operation.
    always_comb begin
        sv         = (shift == '0) ? FULL : {1'b0, shift};
        thresh_eff = (thresh == '0) ? FULL : {1'b0, thresh};
        // One extra bit so count + sv can never wrap before the clamp.
        count_sum  = {1'b0, count} + {1'b0, sv};
        count_post = (count_sum > {1'b0, FULL}) ? FULL : count_sum[CW-1:0];

        if (dir) begin
            shifted = shift_reg >> sv;
            shout   = shift_reg & (ONES >> (FULL - sv));
        end else begin
            shifted = shift_reg << sv;
            shout   = shift_reg >> (FULL - sv);
        end
        dout  = do_shift ? shout : shift_reg;
        empty = (count >= thresh_eff);

        // PULL under autopull is a no-op while the OSR still holds enough bits.
        pull_noop = autopull_en && !empty;
        active    = reset_n && penable && !stalled && !restart && !mov_set;
        stall_req = active && (
                      (do_pull && !pull_noop && !avail && pull_block) ||
                      (!do_pull && do_shift && autopull_en && empty && !avail));

        go         = reset_n && penable && !stalled && !stall_req && !restart;
        mov_op     = go && mov_set;
        pull_op    = go && !mov_set && do_pull && !pull_noop;
        out_op     = go && !mov_set && !do_pull && do_shift;
        // An OUT that finds the OSR drained only refills. The shift happens on the retry.
        out_reload = out_op && autopull_en && empty;
        out_shift  = out_op && !(autopull_en && empty);
        out_chain  = out_shift && autopull_en && avail && (count_post >= thresh_eff);
        load       = (pull_op && avail) || out_reload || out_chain;
        xload      = pull_op && !avail && !pull_block;
    end

    // OSR contents and consumed-bit count. Restart only rewinds the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg <= '0;
            count     <= FULL;
        end else if (restart) begin
            count     <= FULL;
        end else if (mov_op) begin
            shift_reg <= mov_din;
            count     <= '0;
        end else if (load) begin
            shift_reg <= load_data;
            count     <= '0;
        end else if (xload) begin
            shift_reg <= x_val;
            count     <= '0;
        end else if (out_shift) begin
            shift_reg <= shifted;
            count     <= count_post;
        end
    end

`ifdef OSR_PREFETCH_EN
    // Prefetch buffer. A fill wins over a drain, so a same-cycle refill is possible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pf_valid <= 1'b0;
            pf_data  <= '0;
        end else if (fifo.ready) begin
            pf_valid <= 1'b1;
            pf_data  <= fifo.data;
        end else if (load) begin
            pf_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_osr_pull.sv
// Self-checking bench for osr_pull (DW=32). It runs directed scenarios and then
// randomized traffic. A cycle-level behavioural model of the OSR and of the TX
// FIFO queue predicts every output.
module tb_osr_pull;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        penable;
    logic        restart;
    logic        stalled;
    logic        dir;
    logic [4:0]  shift;
    logic [4:0]  thresh;
    logic        autopull_en;
    logic        do_shift;
    logic        do_pull;
    logic        pull_block;
    logic [31:0] x_val;
    logic        mov_set;
    logic [31:0] mov_din;
    logic [31:0] dout;
    logic [5:0]  shift_count;
    logic        empty;
    logic        stall_req;

    osr_pull_if #(.DW(32)) fifo_bus ();

    osr_pull #(.DW(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .penable     (penable),
        .restart     (restart),
        .stalled     (stalled),
        .dir         (dir),
        .shift       (shift),
        .thresh      (thresh),
        .autopull_en (autopull_en),
        .do_shift    (do_shift),
        .do_pull     (do_pull),
        .pull_block  (pull_block),
        .x_val       (x_val),
        .mov_set     (mov_set),
        .mov_din     (mov_din),
        .fifo        (fifo_bus),
        .dout        (dout),
        .shift_count (shift_count),
        .empty       (empty),
        .stall_req   (stall_req)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int pops    = 0;

    // Model state: OSR value, consumed bits, and the words queued in the FIFO.
    longint unsigned m_reg = 0;
    int              m_cnt = 32;
    logic [31:0]     fifo_q[$];
    bit              fifo_gate = 0;
`ifdef OSR_PREFETCH_EN
    bit              m_pfv = 0;
    logic [31:0]     m_pfd = '0;
`endif

    logic [31:0] last_dout;
    logic        last_stall;
    logic        last_ready;
    logic        last_empty;
    logic [5:0]  last_cnt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        fifo_bus.valid = fifo_gate && (fifo_q.size() > 0);
        fifo_bus.data  = (fifo_q.size() > 0) ? fifo_q[0] : $urandom;
    endtask

    // Predict this cycle's outputs from the behavioural rules, then advance the model.
    task automatic model_eval(output logic [31:0] e_dout, output logic e_stall,
                              output logic e_ready, output logic e_empty,
                              output logic [5:0] e_cnt);
        int sv, th, nc;
        bit have, took;
        logic [31:0] word;
        longint unsigned bits;
        if (!reset_n) begin
            m_reg = 0;
            m_cnt = 32;
`ifdef OSR_PREFETCH_EN
            m_pfv = 0;
`endif
            e_dout = '0; e_stall = 1'b0; e_ready = 1'b0; e_empty = 1'b1; e_cnt = 6'd32;
            return;
        end
        sv = (shift == 0) ? 32 : int'(shift);
        th = (thresh == 0) ? 32 : int'(thresh);
`ifdef OSR_PREFETCH_EN
        have = m_pfv;
        word = m_pfd;
`else
        have = fifo_bus.valid;
        word = fifo_bus.data;
`endif
        bits    = dir ? (m_reg % (64'd1 << sv)) : (m_reg >> (32 - sv));
        e_dout  = do_shift ? bits[31:0] : m_reg[31:0];
        e_empty = (m_cnt >= th);
        e_cnt   = 6'(m_cnt);
        e_stall = 1'b0;
        took    = 0;
        if (restart) begin
            m_cnt = 32;
        end else if (penable && !stalled) begin
            if (mov_set) begin
                m_reg = mov_din;
                m_cnt = 0;
            end else if (do_pull) begin
                if (autopull_en && m_cnt < th) begin
                    // nothing to do while bits remain
                end else if (have) begin
                    m_reg = word; m_cnt = 0; took = 1;
                end else if (pull_block) begin
                    e_stall = 1'b1;
                end else begin
                    m_reg = x_val; m_cnt = 0;
                end
            end else if (do_shift) begin
                if (autopull_en && m_cnt >= th) begin
                    if (have) begin
                        m_reg = word; m_cnt = 0; took = 1;
                    end else begin
                        e_stall = 1'b1;
                    end
                end else begin
                    nc = m_cnt + sv;
                    if (nc > 32) nc = 32;
                    m_reg = dir ? (m_reg >> sv) : ((m_reg << sv) & 64'hFFFF_FFFF);
                    m_cnt = nc;
                    if (autopull_en && have && nc >= th) begin
                        m_reg = word; m_cnt = 0; took = 1;
                    end
                end
            end
        end
`ifdef OSR_PREFETCH_EN
        e_ready = fifo_bus.valid && (!m_pfv || took);
        if (e_ready) begin
            m_pfd = fifo_bus.data;
            m_pfv = 1;
            void'(fifo_q.pop_front());
        end else if (took) begin
            m_pfv = 0;
        end
`else
        e_ready = took;
        if (took) void'(fifo_q.pop_front());
`endif
    endtask

    // Caller sets inputs just after a falling edge. This samples, compares and moves to the next falling edge.
    task automatic step();
        logic [31:0] e_dout;
        logic e_stall, e_ready, e_empty;
        logic [5:0] e_cnt;
        drive_fifo();
        #1;
        last_dout  = dout;
        last_stall = stall_req;
        last_ready = fifo_bus.ready;
        last_empty = empty;
        last_cnt   = shift_count;
        if (fifo_bus.ready && fifo_bus.valid) pops++;
        model_eval(e_dout, e_stall, e_ready, e_empty, e_cnt);
        check_eq("dout", 64'(last_dout), 64'(e_dout));
        check_eq("stall_req", 64'(last_stall), 64'(e_stall));
        check_eq("fifo_ready", 64'(last_ready), 64'(e_ready));
        check_eq("empty", 64'(last_empty), 64'(e_empty));
        check_eq("shift_count", 64'(last_cnt), 64'(e_cnt));
        @(negedge clk);
    endtask

    task automatic set_idle();
        penable = 1'b1; restart = 1'b0; stalled = 1'b0;
        do_shift = 1'b0; do_pull = 1'b0; mov_set = 1'b0;
        fifo_gate = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; set_idle(); penable = 1'b0;
        dir = 1'b0; shift = '0; thresh = '0; autopull_en = 1'b0;
        pull_block = 1'b0; x_val = '0; mov_din = '0;
        fifo_bus.valid = 1'b0; fifo_bus.data = '0;
        @(negedge clk);
        step(); step();

        // Reset values
        reset_n = 1'b1;
        step();
        check_eq("rst_count", 64'(last_cnt), 64'd32);
        check_eq("rst_empty", 64'(last_empty), 64'd1);
        check_eq("rst_dout", 64'(last_dout), 64'd0);
        check_eq("rst_ready", 64'(last_ready), 64'd0);

`ifndef OSR_PREFETCH_EN
        // Autopull through four 8-bit right shifts
        set_idle(); autopull_en = 1'b1; dir = 1'b1; shift = 5'd8; thresh = 5'd0;
        fifo_q.push_back(32'hA1B2C3D4);
        do_shift = 1'b1;
        step();
        check_eq("ap_stall", 64'(last_stall), 64'd1);
        fifo_gate = 1;
        step();
        check_eq("ap_load_stall", 64'(last_stall), 64'd0);
        check_eq("ap_load_pop", 64'(last_ready), 64'd1);
        fifo_q.push_back(32'h0BADF00D);
        step();
        check_eq("ap_out1", 64'(last_dout), 64'hD4);
        step();
        check_eq("ap_out2", 64'(last_dout), 64'hC3);
        step();
        check_eq("ap_out3", 64'(last_dout), 64'hB2);
        step();
        check_eq("ap_out4", 64'(last_dout), 64'hA1);
        check_eq("ap_reload", 64'(last_ready), 64'd1);
        set_idle();
        step();
        check_eq("ap_cnt", 64'(last_cnt), 64'd0);
        check_eq("ap_word2", 64'(last_dout), 64'h0BADF00D);
`endif

        // Non-blocking PULL with the FIFO empty takes X
        set_idle(); autopull_en = 1'b0; fifo_q.delete();
        do_pull = 1'b1; pull_block = 1'b0; x_val = 32'h55;
        step();
        check_eq("nb_ready", 64'(last_ready), 64'd0);
        check_eq("nb_stall", 64'(last_stall), 64'd0);
        set_idle();
        step();
        check_eq("nb_reg", 64'(last_dout), 64'h55);
        check_eq("nb_cnt", 64'(last_cnt), 64'd0);

`ifndef OSR_PREFETCH_EN
        // Blocking PULL waits three cycles for data
        set_idle(); fifo_q.push_back(32'h1234); pops = 0;
        do_pull = 1'b1; pull_block = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("bp_stall", 64'(last_stall), 64'd1);
        end
        fifo_gate = 1;
        step();
        check_eq("bp_release", 64'(last_stall), 64'd0);
        check_eq("bp_pop", 64'(last_ready), 64'd1);
        set_idle();
        step();
        check_eq("bp_reg", 64'(last_dout), 64'h1234);
        check_eq("bp_cnt", 64'(last_cnt), 64'd0);
        check_eq("bp_pops", 64'(pops), 64'd1);
`endif

        // Full-width left shift
        set_idle(); mov_set = 1'b1; mov_din = 32'h8000_0001;
        step();
        set_idle(); autopull_en = 1'b0; dir = 1'b0; shift = 5'd0; do_shift = 1'b1;
        step();
        check_eq("fw_dout", 64'(last_dout), 64'h8000_0001);
        set_idle();
        step();
        check_eq("fw_reg", 64'(last_dout), 64'd0);
        check_eq("fw_cnt", 64'(last_cnt), 64'd32);

        // Reset arriving during a blocking-PULL stall
        set_idle(); fifo_q.delete(); fifo_q.push_back(32'hCAFE_0001);
        do_pull = 1'b1; pull_block = 1'b1;
        step();
        check_eq("rs_stall", 64'(last_stall), 64'd1);
        reset_n = 1'b0; fifo_gate = 1;
        step();
        check_eq("rs_ready", 64'(last_ready), 64'd0);
        check_eq("rs_stall_clr", 64'(last_stall), 64'd0);
        reset_n = 1'b1; set_idle();
        step();
        check_eq("rs_cnt", 64'(last_cnt), 64'd32);
        fifo_q.delete();

`ifdef OSR_PREFETCH_EN
        // Prefetch pops a lone word early, so the first autopull OUT does not stall
        set_idle(); fifo_q.push_back(32'hA1B2C3D4); fifo_gate = 1;
        step();
        check_eq("pf_early_pop", 64'(last_ready), 64'd1);
        autopull_en = 1'b1; dir = 1'b1; shift = 5'd8; thresh = 5'd0; do_shift = 1'b1;
        step();
        check_eq("pf_no_stall", 64'(last_stall), 64'd0);
        step();
        check_eq("pf_out1", 64'(last_dout), 64'hD4);
`endif

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            reset_n     = ($urandom_range(0, 149) != 0);
            penable     = ($urandom_range(0, 9) != 0);
            stalled     = ($urandom_range(0, 9) == 0);
            restart     = ($urandom_range(0, 39) == 0);
            dir         = 1'($urandom);
            shift       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            thresh      = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
            autopull_en = ($urandom_range(0, 2) != 0);
            do_shift    = 1'($urandom);
            do_pull     = ($urandom_range(0, 5) == 0);
            pull_block  = 1'($urandom);
            x_val       = $urandom;
            mov_set     = ($urandom_range(0, 19) == 0);
            mov_din     = $urandom;
            fifo_gate   = ($urandom_range(0, 9) < 7);
            if (fifo_q.size() < 3 && $urandom_range(0, 2) == 0) fifo_q.push_back($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/osr_pull.md
Name: osr_pull

Overview:
- Parametrised output shift register for the PIO state machine, with autopull and a TX FIFO valid/ready handshake built in.
- Generalises the fixed 32-bit OSR to width DW and a programmable pull threshold.
- Adds explicit PULL (blocking and non-blocking), MOV-to-OSR, and a stall request back to the instruction sequencer.
- Sits between the TX FIFO and the OUT/PULL datapath of one state machine.

Parameters:
DW, 32, data width; power of two, 8..64
SHW, $clog2(DW), width of the shift and thresh fields
CW, $clog2(DW)+1, width of shift_count (holds 0..DW)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
penable  input  1  state-machine enable
restart  input  1  SM restart; synchronous; clears count only
stalled  input  1  SM stalled by other cause; no state update
dir  input  1  0 shift left (MSB out), 1 shift right (LSB out)
shift  input  SHW  OUT bit count; 0 means DW
thresh  input  SHW  autopull threshold; 0 means DW
autopull_en  input  1  autopull enable
do_shift  input  1  OUT instruction active
do_pull  input  1  PULL instruction active
pull_block  input  1  PULL blocks when no data available
x_val  input  DW  X scratch; loaded by a non-blocking PULL that finds no data
mov_set  input  1  MOV OSR, src
mov_din  input  DW  MOV source data
fifo_data  input  DW  TX FIFO head
fifo_valid  input  1  TX FIFO not empty
fifo_ready  output  1  TX FIFO pop strobe
dout  output  DW  right-aligned shifted-out bits when do_shift, else shift_reg
shift_count  output  CW  bits consumed, 0..DW
empty  output  1  shift_count >= thresh_eff
stall_req  output  1  sequencer must hold the current instruction

Behaviour:
- Reset (reset_n low, async): shift_reg=0, count=DW, prefetch buffer empty. fifo_ready=0, stall_req=0, empty=1, dout=0.
- Update condition: state updates only when penable && !stalled && !stall_req. The exception is restart, which acts whenever asserted.
- Priority: restart > mov_set > do_pull > do_shift.
- restart: count<=DW. shift_reg is unchanged.
- mov_set: shift_reg<=mov_din, count<=0. No FIFO pop.
- Shift amount sv = (shift==0)?DW:shift.
  - dir=1: new = shift_reg>>sv; dout = low sv bits, right-aligned.
  - dir=0: new = shift_reg<<sv; dout = top sv bits, right-aligned.
  - sv==DW gives new=0.
- Count arithmetic: count <= min(count+sv, DW), computed CW+1 bits wide so it cannot overflow.
- OUT with count >= thresh_eff on entry and autopull_en: stall_req=1, no shift. The instruction retries until data is available, then a load occurs (shift_reg<=data, count<=0); the shift executes on the following cycle.
- OUT completing: if autopull_en, data is available, and the lookahead count (post-shift) >= thresh_eff, the load happens in the same cycle. shift_reg<=data, count<=0, pop; the shifted-out bits still come from the old shift_reg.
- do_pull, data available: shift_reg<=data, count<=0, pop.
- do_pull, no data, pull_block=1: stall_req=1.
- do_pull, no data, pull_block=0: shift_reg<=x_val, count<=0.
- do_pull with autopull_en and count < thresh_eff: no operation (PIO IfEmpty semantics).
- Data available means fifo_valid (or pf_valid under OSR_PREFETCH_EN).
- fifo_ready is combinational and asserted only in the cycle the word is consumed. Pop = fifo_valid && fifo_ready. fifo_ready is never asserted while fifo_valid=0.
- stall_req is combinational. It deasserts in the same cycle data becomes available, and the load then completes.
- Reset mid-stall: all state clears and no pop occurs.

Optional Feature:
- Macro: OSR_PREFETCH_EN.
- Defined:
  - One-entry buffer (pf_data, pf_valid) is filled from the FIFO whenever pf_valid=0 && fifo_valid. This fill asserts fifo_ready.
  - All loads (autopull, PULL) take pf_data. A same-cycle refill is allowed.
  - restart does not flush the buffer; reset does.
  - Effect: autopull never sees FIFO read latency; a lone word is popped early.
- Undefined: loads come straight from fifo_data; no buffer registers exist.

Test Plan:
- Reset, DW=32: after reset_n rises -> shift_count=32, empty=1, dout=0, fifo_ready=0.
- Autopull, thresh=32, dir=1, shift=8, FIFO word 0xA1B2C3D4, four OUTs:
  - OUT 1 -> stall 1 cycle, load, then dout=0xD4.
  - OUTs 2-4 -> dout=0xC3, 0xB2, 0xA1.
  - OUT 4 -> shift_count=32, with an immediate reload if FIFO valid.
- Non-blocking PULL, FIFO empty, x_val=0x55 -> shift_reg=0x55, count=0, fifo_ready=0, stall_req=0.
- Blocking PULL, FIFO empty for 3 cycles then valid with 0x1234 -> stall_req high 3 cycles, then load 0x1234, one pop.
- dir=0, shift=0 (full width) on 0x80000001 -> dout=0x80000001, new shift_reg=0, count=32.
- OSR_PREFETCH_EN, FIFO valid before first OUT -> prefetch pop at once; first autopull OUT has zero stall cycles.
